// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_seq_pkg
// Brief   : State encoding and shared constants for the CPU micro-sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

  localparam int MAX_UOPS_DEFAULT = 3;
  localparam int UOP_IDX_W        = 2;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    DISPATCH = 3'd2,
    SEL      = 3'd3,
    EXEC     = 3'd4,
    RETIRE   = 3'd5,
    HALT     = 3'd6,
    FAULT    = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_fetch_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : fetch_watchdog
// Brief   : Counts FETCH cycles without mem_ready; flags the last allowed one.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_timeout
);

  localparam int c_W = $clog2(FETCH_TIMEOUT + 1);

  logic [c_W-1:0] r_count;

  // o_timeout marks the FETCH_TIMEOUT-th stalled cycle, so the FSM can fault on that edge
  assign o_timeout = (r_count == c_W'(FETCH_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_timeout) begin
      r_count <= r_count + c_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sequencer
// Brief   : Micro-sequencer issuing one-hot phase strobes per decoded micro-op.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MAX_UOPS      = MAX_UOPS_DEFAULT,
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_ready,
  input  logic [1:0]           uop_cnt,
  input  logic                 halt_req,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic [MAX_UOPS-1:0]  sel_en,
  output logic [MAX_UOPS-1:0]  exec_en,
  output logic                 eip_update,
  output logic [1:0]           uop_idx,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_W-1:0]     instr_count
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [UOP_IDX_W-1:0]   r_cnt_q;
  logic [UOP_IDX_W-1:0]   r_uop_idx;
  logic                   r_halt_pending;
  logic [CNT_W-1:0]       r_instr_count;
  logic                   w_wd_en;
  logic                   w_wd_clear;
  logic                   w_wd_timeout;
  logic                   w_uop_illegal;
  logic                   w_last_uop;
  logic                   w_strobe_ok;
  logic [MAX_UOPS-1:0]    w_onehot;

  fetch_watchdog #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_en      (w_wd_en),
    .o_timeout (w_wd_timeout)
  );

  assign w_uop_illegal = (uop_cnt == 2'd0) || (int'(uop_cnt) > MAX_UOPS);
  assign w_last_uop    = (r_uop_idx == (r_cnt_q - UOP_IDX_W'(1)));
  assign w_onehot      = MAX_UOPS'(1) << r_uop_idx;

  always_comb begin
    w_next_state = r_state;
    w_wd_en      = 1'b0;
    w_wd_clear   = (r_state != FETCH);
    case (r_state)
      FETCH: begin
        if (mem_ready) begin
          w_next_state = DECODE;
        end else begin
          w_wd_en = 1'b1;
          if (w_wd_timeout) w_next_state = FAULT;
        end
      end
      DECODE:   w_next_state = DISPATCH;
      DISPATCH: w_next_state = w_uop_illegal ? FAULT : SEL;
      SEL:      w_next_state = EXEC;
      EXEC:     w_next_state = w_last_uop ? RETIRE : SEL;
      RETIRE:   w_next_state = (r_halt_pending || halt_req) ? HALT : FETCH;
      HALT:     w_next_state = HALT;
      FAULT:    w_next_state = FAULT;
      default:  w_next_state = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= FETCH;
      r_cnt_q        <= '0;
      r_uop_idx      <= '0;
      r_halt_pending <= 1'b0;
      r_instr_count  <= '0;
    end else begin
      r_state <= w_next_state;
      if (halt_req) r_halt_pending <= 1'b1;
      case (r_state)
        DISPATCH: begin
          r_cnt_q   <= uop_cnt;
          r_uop_idx <= '0;
        end
        EXEC:     if (!w_last_uop) r_uop_idx <= r_uop_idx + UOP_IDX_W'(1);
        RETIRE:   r_instr_count <= r_instr_count + CNT_W'(1);
        default:  ;
      endcase
    end
  end

  // Strobes are masked while reset is held so a mid-instruction reset fires nothing
  assign w_strobe_ok = !reset;
  assign fetch_en    = w_strobe_ok && (r_state == FETCH);
  assign decode_en   = w_strobe_ok && (r_state == DECODE);
  assign sel_en      = (w_strobe_ok && (r_state == SEL))  ? w_onehot : '0;
  assign exec_en     = (w_strobe_ok && (r_state == EXEC)) ? w_onehot : '0;
  assign eip_update  = w_strobe_ok && (r_state == RETIRE);
  assign uop_idx     = r_uop_idx;
  assign halted      = (r_state == HALT) || (r_state == FAULT);
  assign busy        = !halted;
  assign fault       = (r_state == FAULT);
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Central micro-sequencer for the multi-phase CPU datapath.
- Generates single-cycle enable strobes to fetch, decode, operand selector, ALU/register write-back and EIP update.
- Strobes follow the micro-op count that decode reports, so short instructions do not burn unused phases.
- Adds a fetch watchdog, halt handling and a retired-instruction counter.

Parameters:
MAX_UOPS, 3, maximum micro-ops per instruction; width of sel_en/exec_en
CNT_W, 16, width of instr_count
FETCH_TIMEOUT, 15, max cycles in FETCH without mem_ready before fault

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  synchronous, active-high reset
mem_ready  input  1  instruction memory has data valid this cycle
uop_cnt  input  2  micro-op count from decode, valid in DISPATCH cycle; 0 = illegal
halt_req  input  1  request stop at next instruction boundary
fetch_en  output  1  fetch strobe
decode_en  output  1  decode strobe
sel_en  output  MAX_UOPS  one-hot operand-select strobe for micro-op k
exec_en  output  MAX_UOPS  one-hot ALU execute + register load strobe for micro-op k
eip_update  output  1  advance EIP
uop_idx  output  2  current micro-op index
busy  output  1  not in HALT/FAULT
halted  output  1  in HALT or FAULT
fault  output  1  in FAULT
instr_count  output  CNT_W  retired instructions

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - State goes to FETCH.
  - All strobes 0, uop_idx 0, instr_count 0, halt_pending 0, watchdog 0.
  - busy 1, halted 0, fault 0.
- All outputs are Moore, decoded from the state register.
- States and transitions:
  - FETCH: fetch_en=1 every cycle. If mem_ready=1, go to DECODE. Else watchdog++. If watchdog reaches FETCH_TIMEOUT with mem_ready=0, go to FAULT.
  - DECODE: decode_en=1 for one cycle; go to DISPATCH.
  - DISPATCH: sample uop_cnt into cnt_q. 0 goes to FAULT; otherwise uop_idx=0 and go to SEL.
  - SEL: sel_en[uop_idx]=1 for one cycle; go to EXEC.
  - EXEC: exec_en[uop_idx]=1 for one cycle. If uop_idx==cnt_q-1, go to RETIRE; else uop_idx++ and go to SEL.
  - RETIRE: eip_update=1 and instr_count++ (wraps modulo 2^CNT_W). If halt_pending or halt_req, go to HALT; else go to FETCH.
  - HALT: halted=1, busy=0, all strobes 0. Terminal until reset.
  - FAULT: fault=1, halted=1, busy=0, all strobes 0. Terminal until reset.
- Latency with mem_ready immediate: 1 uop = 6 cycles/instruction; each extra uop adds 2 (3 uops = 10).
- halt_req:
  - Sticky into halt_pending; only reset clears it.
  - Never aborts an instruction mid-flight; takes effect at RETIRE only.
  - Asserted during the RETIRE cycle itself, it still halts at that RETIRE.
- Fault priority: a watchdog timeout or illegal uop_cnt goes to FAULT even with halt pending. A faulted instruction does not increment instr_count.
- Watchdog clears on entry to FETCH.
- uop_cnt above MAX_UOPS cannot occur at the default MAX_UOPS=3 (2-bit field). For MAX_UOPS<3, it is treated as illegal and goes to FAULT.
- Reset mid-instruction: next cycle is FETCH with all counters cleared. No strobe pulses in the reset cycle.
- At most one strobe is high in any cycle (one-hot invariant).

Decomposition:
- Package cpu_seq_pkg holds:
  - state encoding constants: FETCH, DECODE, DISPATCH, SEL, EXEC, RETIRE, HALT, FAULT;
  - MAX_UOPS default;
  - UOP_IDX_W=2.
- One sub-module, fetch_watchdog: counter with clear/enable/timeout output, parameterised by FETCH_TIMEOUT.

Test Plan:
- Reset, then mem_ready=1 constantly, uop_cnt=1 -> strobe order fetch, decode, (dispatch), sel_en=001, exec_en=001, eip_update; instr_count=1 after 6 cycles, 2 after 12.
- uop_cnt=3 -> sel/exec alternate with sel_en 001,010,100 and uop_idx 0,1,2; eip_update in cycle 10; instr_count=1.
- mem_ready held 0 for 15 cycles -> FAULT: fault=1, halted=1, busy=0, strobes 0. mem_ready high on cycle 14 -> no fault, proceeds to DECODE.
- uop_cnt=0 at DISPATCH -> FAULT next cycle; instr_count unchanged.
- Pulse halt_req one cycle during SEL of a 3-uop instruction -> instruction completes (eip_update seen, count+1), then HALT with halted=1, fault=0.
- Assert reset during EXEC of uop 1 -> next cycle FETCH, uop_idx=0, instr_count=0, no exec_en pulse. Run 65536 one-uop instructions -> instr_count wraps to 0.
